// File: rtl/rr_arbiter8_pkg.sv
// Shared types and helpers for the 8-way round-robin arbiter: FSM encoding, sizes, one-hot decode.
// Purely declarative; no latency or backpressure of its own.
package arb_pkg;

    localparam logic ARB_IDLE  = 1'b0;
    localparam logic ARB_GRANT = 1'b1;
    localparam int   N_REQ     = 8;
    localparam int   IDX_W     = 3;

    typedef enum logic {
        ST_IDLE  = ARB_IDLE,
        ST_GRANT = ARB_GRANT
    } arb_state_e;

    function automatic logic [N_REQ-1:0] onehot8(input logic [IDX_W-1:0] idx);
        onehot8 = N_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_arbiter8_if.sv
// Request/grant bundle between the requesting masters and the arbiter.
// Masters drive req and observe the grant; the arbiter is the slave side.
interface rr_arbiter8_if;
    import arb_pkg::*;

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] gnt;
    logic [IDX_W-1:0] gnt_idx;
    logic             gnt_valid;
    logic             timeout;

    modport master (
        output req,
        input  gnt,
        input  gnt_idx,
        input  gnt_valid,
        input  timeout
    );

    modport slave (
        input  req,
        output gnt,
        output gnt_idx,
        output gnt_valid,
        output timeout
    );

endinterface

// File: rtl/rr_arbiter8_prienc8.sv
// 8:3 priority encoder, highest set bit wins; combinational, zero latency.
// en=0 or d=0 yields b=0, valid=0.
module prienc8 (
    input  logic [7:0] d,
    input  logic       en,
    output logic [2:0] b,
    output logic       valid
);

    always_comb begin
        b     = 3'd0;
        valid = 1'b0;
        if (en) begin
            for (int i = 0; i < 8; i++) begin
                if (d[i]) begin
                    b     = 3'(i);
                    valid = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter, 8 requesters: registered one-hot grant 1 clock after req, held until req drops.
// Requesters wait on a level req; macro ARB_TIMEOUT_EN adds a forced release after MAX_HOLD cycles.
module rr_arbiter8
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
) (
    input  logic         clk,
    input  logic         rst,
    rr_arbiter8_if.slave bus
);

    arb_state_e       state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
    logic             gnt_valid_q, gnt_valid_d;
    logic [IDX_W-1:0] last_q, last_d;
    logic [N_REQ-1:0] masked;
    logic [N_REQ-1:0] enc_in;
    logic [IDX_W-1:0] enc_idx;
    logic             enc_valid;

`ifdef ARB_TIMEOUT_EN
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic             timeout_q, timeout_d;
`else
    logic unused_cfg;
    assign unused_cfg = ^{32'(MAX_HOLD), 32'(CNT_W)};
`endif

    // Only requesters below the last winner compete first; fall back to raw req on wrap.
    assign masked = bus.req & (onehot8(last_q) - N_REQ'(1));
    assign enc_in = (masked != '0) ? masked : bus.req;

    prienc8 u_enc (
        .d     (enc_in),
        .en    (state_q == ST_IDLE),
        .b     (enc_idx),
        .valid (enc_valid)
    );

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        gnt_idx_d   = gnt_idx_q;
        gnt_valid_d = gnt_valid_q;
        last_d      = last_q;
`ifdef ARB_TIMEOUT_EN
        hold_cnt_d  = hold_cnt_q;
        timeout_d   = 1'b0;
`endif
        if (state_q == ST_IDLE) begin
            if (enc_valid) begin
                state_d     = ST_GRANT;
                gnt_d       = onehot8(enc_idx);
                gnt_idx_d   = enc_idx;
                gnt_valid_d = 1'b1;
                last_d      = enc_idx;
`ifdef ARB_TIMEOUT_EN
                hold_cnt_d  = CNT_W'(1);
`endif
            end
        end else begin
            if (!bus.req[gnt_idx_q]) begin
                state_d     = ST_IDLE;
                gnt_d       = '0;
                gnt_valid_d = 1'b0;
`ifdef ARB_TIMEOUT_EN
            end else if (hold_cnt_q == CNT_W'(MAX_HOLD)) begin
                state_d     = ST_IDLE;
                gnt_d       = '0;
                gnt_valid_d = 1'b0;
                timeout_d   = 1'b1;
            end else begin
                hold_cnt_d  = hold_cnt_q + CNT_W'(1);
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            gnt_q       <= '0;
            gnt_idx_q   <= '0;
            gnt_valid_q <= 1'b0;
            last_q      <= '0;
`ifdef ARB_TIMEOUT_EN
            hold_cnt_q  <= '0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gnt_idx_q   <= gnt_idx_d;
            gnt_valid_q <= gnt_valid_d;
            last_q      <= last_d;
`ifdef ARB_TIMEOUT_EN
            hold_cnt_q  <= hold_cnt_d;
            timeout_q   <= timeout_d;
`endif
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_idx   = gnt_idx_q;
    assign bus.gnt_valid = gnt_valid_q;
`ifdef ARB_TIMEOUT_EN
    assign bus.timeout   = timeout_q;
`else
    assign bus.timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_rr_arbiter8.sv
// Bench for rr_arbiter8: directed request patterns push expected grant indices into a queue,
// and a negedge monitor pops and compares each new grant while checking per-cycle invariants.
module tb_rr_arbiter8;
    import arb_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    rr_arbiter8_if bus();

    rr_arbiter8 #(.MAX_HOLD(4), .CNT_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          exp_q[$];
    logic [7:0]  req_smp    = '0;
    logic        prev_valid = 1'b0;
    logic [2:0]  prev_idx   = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt();
        int n = 0;
        while (bus.gnt_valid !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check("wait_gnt_in_time", 32'(bus.gnt_valid), 32'd1);
    endtask

    // Serve `count` grants from a held pattern; winner drops its bit after `hold` cycles, then reasserts.
    task automatic serve(input logic [7:0] pat, input int hold, input int count);
        bus.req = pat;
        for (int g = 0; g < count; g++) begin
            wait_gnt();
            repeat (hold) tick();
            bus.req = pat & ~onehot8(bus.gnt_idx);
            tick();
            check("dead_cycle_gnt", 32'(bus.gnt), 32'd0);
            bus.req = (g == count - 1) ? 8'h00 : pat;
        end
        tick();
    endtask

    always @(posedge clk) req_smp = bus.req;

    always @(negedge clk) begin
        int e;
        check("onehot0_gnt", 32'($onehot0(bus.gnt)), 32'd1);
        check("valid_eq_or_gnt", 32'(bus.gnt_valid), 32'(|bus.gnt));
        if (bus.gnt_valid === 1'b1 && prev_valid !== 1'b1) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_grant: got idx %0d expected none at %0t", bus.gnt_idx, $time);
            end else begin
                e = exp_q.pop_front();
                check("grant_idx", 32'(bus.gnt_idx), 32'(e));
                check("grant_vector", 32'(bus.gnt), 32'(onehot8(3'(e))));
            end
            check("granted_req_was_set", 32'(req_smp[bus.gnt_idx]), 32'd1);
        end else if (bus.gnt_valid === 1'b1 && bus.gnt_idx !== prev_idx) begin
            n_tests++;
            n_fail++;
            $display("FAIL no_dead_cycle: got idx %0d expected %0d held", bus.gnt_idx, prev_idx);
        end
        prev_valid = bus.gnt_valid;
        prev_idx   = bus.gnt_idx;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected end of run");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        bus.req = 8'hFF;

        // Reset with all requests pending, then first grant to bit 7.
        for (int c = 0; c < 2; c++) begin
            tick();
            check("rst_gnt", 32'(bus.gnt), 32'd0);
            check("rst_gnt_idx", 32'(bus.gnt_idx), 32'd0);
            check("rst_gnt_valid", 32'(bus.gnt_valid), 32'd0);
            check("rst_timeout", 32'(bus.timeout), 32'd0);
        end
        rst = 1'b0;
        exp_q.push_back(7);
        tick();
        check("first_gnt_latency", 32'(bus.gnt), 32'h80);
        check("first_gnt_idx", 32'(bus.gnt_idx), 32'd7);
        bus.req = 8'h00;
        tick();
        check("first_release", 32'(bus.gnt_valid), 32'd0);

        // Two requesters alternate.
        exp_q.push_back(5); exp_q.push_back(1); exp_q.push_back(5); exp_q.push_back(1);
        serve(8'h22, 3, 4);

        // Single low requester, then wrap to bit 7 from last=0.
        exp_q.push_back(0);
        serve(8'h01, 2, 1);
        exp_q.push_back(7);
        serve(8'h81, 2, 1);

        // Bring last back to 0, then full rotation with all requesting.
        exp_q.push_back(0);
        serve(8'h01, 1, 1);
        for (int i = 7; i >= 0; i--) exp_q.push_back(i);
        exp_q.push_back(7);
        serve(8'hFF, 1, 9);

        // Reset in the middle of a grant to bit 3.
        bus.req = 8'h08;
        exp_q.push_back(3);
        wait_gnt();
        tick();
        check("mid_grant_gnt", 32'(bus.gnt), 32'h08);
        rst = 1'b1;
        tick();
        check("mid_rst_gnt", 32'(bus.gnt), 32'd0);
        check("mid_rst_valid", 32'(bus.gnt_valid), 32'd0);
        check("mid_rst_idx", 32'(bus.gnt_idx), 32'd0);
        rst = 1'b0;
        exp_q.push_back(3);
        serve(8'h0C, 1, 1);

        // Fresh reset, then two requesters held forever.
        rst = 1'b1;
        bus.req = 8'h00;
        tick();
        tick();
        rst = 1'b0;
        bus.req = 8'h11;
`ifdef ARB_TIMEOUT_EN
        exp_q.push_back(4); exp_q.push_back(0); exp_q.push_back(4);
        for (int g = 0; g < 3; g++) begin
            wait_gnt();
            n = 0;
            while (bus.gnt_valid === 1'b1 && n < 20) begin
                check("no_timeout_while_held", 32'(bus.timeout), 32'd0);
                tick();
                n++;
            end
            check("hold_cycles", 32'(n), 32'd4);
            check("timeout_pulse", 32'(bus.timeout), 32'd1);
            if (g == 2) bus.req = 8'h00;
        end
        tick();
        check("timeout_one_cycle", 32'(bus.timeout), 32'd0);
`else
        exp_q.push_back(4);
        wait_gnt();
        for (int c = 0; c < 30; c++) begin
            tick();
            check("held_idx", 32'(bus.gnt_idx), 32'd4);
            check("held_valid", 32'(bus.gnt_valid), 32'd1);
            check("held_no_timeout", 32'(bus.timeout), 32'd0);
        end
        bus.req = 8'h00;
        tick();
`endif
        tick();
        tick();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
